vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 sync generator used by the demo tops.
- Produces hpos/vpos, hsync/vsync and display_on from fully parametrised timing.
- Adds selectable sync polarity, a pixel clock-enable divider, and a configurable sync/blank pipeline delay so sync lines up with multi-stage pixel datapaths.
- Adds line/frame strobes and a frame counter, so tops no longer build their own.

---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster/sync generator with pixel divider and sync delay line.
// Define VGA_TIMING_GENLOCK_EN to add the restart (genlock) input.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 1,
    parameter int PIX_DIV   = 1,
    parameter int PIPE      = 1,
    parameter int FRAME_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
`ifdef VGA_TIMING_GENLOCK_EN
    input  logic               restart,
`endif
    output logic               pix_ce,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               hblank,
    output logic               vblank,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be 1..16");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE must be 0..4");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP   = 11'(H_DISPLAY);
    localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_DISP   = 11'(V_DISPLAY);
    localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);
    localparam logic        POL      = (SYNC_POL != 0);

    logic [3:0]         div_q, div_d;
    logic [9:0]         hpos_q, hpos_d;
    logic [9:0]         vpos_q, vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ce;
    logic               restart_w;

`ifdef VGA_TIMING_GENLOCK_EN
    assign restart_w = restart;
`else
    assign restart_w = 1'b0;
`endif

    always_comb begin
        ce      = (div_q == DIV_LAST);
        div_d   = ce ? 4'd0 : div_q + 4'd1;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (ce) begin
            if (hpos_q == H_LAST) begin
                hpos_d = 10'd0;
                if (vpos_q == V_LAST) begin
                    vpos_d  = 10'd0;
                    frame_d = frame_q + FRAME_W'(1);
                end else begin
                    vpos_d = vpos_q + 10'd1;
                end
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end
        // Genlock overrides any wrap on the same edge, frame count included.
        if (restart_w) begin
            div_d   = 4'd0;
            hpos_d  = 10'd0;
            vpos_d  = 10'd0;
            frame_d = frame_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= 4'd0;
            hpos_q  <= 10'd0;
            vpos_q  <= 10'd0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
        end
    end

    logic [10:0] hx, vx;
    logic [4:0]  raw, tap;

    assign hx  = {1'b0, hpos_q};
    assign vx  = {1'b0, vpos_q};
    assign raw = {(hx >= HS_BEG) && (hx < HS_END),
                  (vx >= VS_BEG) && (vx < VS_END),
                  (hx < H_DISP) && (vx < V_DISP),
                  (hx >= H_DISP),
                  (vx >= V_DISP)};

    // Delay line runs every clk so it tracks datapath stages, not pixels.
    if (PIPE == 0) begin : g_comb
        assign tap = raw;
    end else begin : g_pipe
        logic [4:0] stage_q [PIPE];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE; i++) stage_q[i] <= 5'd0;
            end else begin
                stage_q[0] <= raw;
                for (int i = 1; i < PIPE; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign tap = stage_q[PIPE-1];
    end

    assign pix_ce      = ce;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_count = frame_q;
    assign hsync       = tap[4] ? POL : ~POL;
    assign vsync       = tap[3] ? POL : ~POL;
    assign display_on  = tap[2];
    assign hblank      = tap[1];
    assign vblank      = tap[0];
    assign line_start  = ce & (hpos_q == 10'd0);
    assign frame_start = line_start & (vpos_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen over three parameter sets.
// Delayed outputs are checked against raw terms queued PIPE clocks earlier.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef VGA_TIMING_GENLOCK_EN
    logic restart = 1'b0;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic        c0_pix, c0_hs, c0_vs, c0_de, c0_hb, c0_vb, c0_ls, c0_fs;
    logic [9:0]  c0_h, c0_v;
    logic [11:0] c0_fc;
    logic        c1_pix, c1_hs, c1_vs, c1_de, c1_hb, c1_vb, c1_ls, c1_fs;
    logic [9:0]  c1_h, c1_v;
    logic [3:0]  c1_fc;
    logic        c2_pix, c2_hs, c2_vs, c2_de, c2_hb, c2_vb, c2_ls, c2_fs;
    logic [9:0]  c2_h, c2_v;
    logic [2:0]  c2_fc;

    vga_timing_gen u0 (
        .clk(clk), .reset(reset),
`ifdef VGA_TIMING_GENLOCK_EN
        .restart(restart),
`endif
        .pix_ce(c0_pix), .hpos(c0_h), .vpos(c0_v),
        .hsync(c0_hs), .vsync(c0_vs), .display_on(c0_de),
        .hblank(c0_hb), .vblank(c0_vb),
        .line_start(c0_ls), .frame_start(c0_fs), .frame_count(c0_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(0), .PIX_DIV(2), .PIPE(3), .FRAME_W(4)
    ) u1 (
        .clk(clk), .reset(reset),
`ifdef VGA_TIMING_GENLOCK_EN
        .restart(restart),
`endif
        .pix_ce(c1_pix), .hpos(c1_h), .vpos(c1_v),
        .hsync(c1_hs), .vsync(c1_vs), .display_on(c1_de),
        .hblank(c1_hb), .vblank(c1_vb),
        .line_start(c1_ls), .frame_start(c1_fs), .frame_count(c1_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1), .PIX_DIV(1), .PIPE(0), .FRAME_W(3)
    ) u2 (
        .clk(clk), .reset(reset),
`ifdef VGA_TIMING_GENLOCK_EN
        .restart(restart),
`endif
        .pix_ce(c2_pix), .hpos(c2_h), .vpos(c2_v),
        .hsync(c2_hs), .vsync(c2_vs), .display_on(c2_de),
        .hblank(c2_hb), .vblank(c2_vb),
        .line_start(c2_ls), .frame_start(c2_fs), .frame_count(c2_fc)
    );

    typedef struct {
        int div;
        int h;
        int v;
        int f;
    } mst_t;

    function automatic mst_t mstep(mst_t s, int ht, int vt, int pd, int fw);
        mst_t n;
        n = s;
        if (s.div == pd - 1) begin
            n.div = 0;
            if (s.h == ht - 1) begin
                n.h = 0;
                if (s.v == vt - 1) begin
                    n.v = 0;
                    n.f = (s.f + 1) % (1 << fw);
                end else begin
                    n.v = s.v + 1;
                end
            end else begin
                n.h = s.h + 1;
            end
        end else begin
            n.div = s.div + 1;
        end
        return n;
    endfunction

    function automatic logic [4:0] mraw(int h, int v, int hd, int hf, int hs,
                                        int vd, int vf, int vs);
        return {h >= hd + hf && h < hd + hf + hs,
                v >= vd + vf && v < vd + vf + vs,
                h < hd && v < vd, h >= hd, v >= vd};
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({c0_h, c0_v, c0_fc, c0_hs, c0_vs, c0_de, c0_hb, c0_vb}
            !== {10'd0, 10'd0, 12'd0, 5'b00000}) begin
            errors++;
            $display("FAIL reset_u0 got h=%0d v=%0d fc=%0d hs=%b vs=%b de=%b hb=%b vb=%b want 0s",
                     c0_h, c0_v, c0_fc, c0_hs, c0_vs, c0_de, c0_hb, c0_vb);
        end
        checks++;
        if ({c1_pix, c1_hs, c1_vs, c1_de, c1_hb, c1_vb} !== 6'b011000) begin
            errors++;
            $display("FAIL reset_u1 got ce=%b hs=%b vs=%b de=%b hb=%b vb=%b want 0 1 1 0 0 0",
                     c1_pix, c1_hs, c1_vs, c1_de, c1_hb, c1_vb);
        end
        checks++;
        if ({c0_pix, c2_pix, c2_fc} !== {1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_ce got u0=%b u2=%b fc2=%0d want 1 1 0", c0_pix, c2_pix, c2_fc);
        end
    endtask

    task automatic test_defaults;
        mst_t s;
        logic [4:0] q[$];
        logic [4:0] e;
        logic ce, ls, fs;
        logic [39:0] obs, exp;
        int nls, nfs, nhs, nde;
        s = '{0, 0, 0, 0};
        q = {};
        q.push_back(5'd0);
        nls = 0; nfs = 0; nhs = 0; nde = 0;
        do_reset;
        for (int c = 0; c < 2450; c++) begin
            ce = (s.div == 0);
            ls = ce && s.h == 0;
            fs = ls && s.v == 0;
            q.push_back(mraw(s.h, s.v, 640, 16, 96, 480, 10, 2));
            e = q.pop_front();
            exp = {ce, 10'(s.h), 10'(s.v), 12'(s.f), e, ls, fs};
            obs = {c0_pix, c0_h, c0_v, c0_fc, c0_hs, c0_vs, c0_de, c0_hb, c0_vb, c0_ls, c0_fs};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL dflt_cyc%0d got %h want %h", c, obs, exp);
            end
            nls += int'(c0_ls); nfs += int'(c0_fs);
            nhs += int'(c0_hs); nde += int'(c0_de);
            @(posedge clk);
            s = mstep(s, 800, 525, 1, 12);
            @(negedge clk);
        end
        checks++;
        if (nls !== 4 || nfs !== 1) begin
            errors++;
            $display("FAIL dflt_strobes got ls=%0d fs=%0d want 4 1", nls, nfs);
        end
        checks++;
        if (nhs !== 288 || nde !== 1969) begin
            errors++;
            $display("FAIL dflt_counts got hs=%0d de=%0d want 288 1969", nhs, nde);
        end
    endtask

    task automatic test_div_pipe;
        mst_t s;
        logic [4:0] q[$];
        logic [4:0] e;
        logic ce, ls, fs;
        logic [31:0] obs, exp;
        logic [3:0] prev_fc;
        int nfs, wrap_c, h10_c, hs_c;
        s = '{0, 0, 0, 0};
        q = {};
        repeat (3) q.push_back(5'd0);
        nfs = 0; wrap_c = -1; h10_c = -1; hs_c = -1;
        prev_fc = 4'd0;
        do_reset;
        for (int c = 0; c < 4340; c++) begin
            ce = (s.div == 1);
            ls = ce && s.h == 0;
            fs = ls && s.v == 0;
            q.push_back(mraw(s.h, s.v, 8, 2, 3, 5, 1, 2));
            e = q.pop_front();
            exp = {ce, 10'(s.h), 10'(s.v), 4'(s.f), ~e[4], ~e[3], e[2:0], ls, fs};
            obs = {c1_pix, c1_h, c1_v, c1_fc, c1_hs, c1_vs, c1_de, c1_hb, c1_vb, c1_ls, c1_fs};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL divpipe_cyc%0d got %h want %h", c, obs, exp);
            end
            if (c < 4) begin
                checks++;
                if (c1_pix !== 1'(c % 2)) begin
                    errors++;
                    $display("FAIL divpipe_ce%0d got %b want %b", c, c1_pix, 1'(c % 2));
                end
            end
            nfs += int'(c1_fs);
            if (c1_fc == 4'd0 && prev_fc == 4'd15) wrap_c = c;
            prev_fc = c1_fc;
            if (h10_c < 0 && c1_h == 10'd10) h10_c = c;
            if (hs_c < 0 && c1_hs == 1'b0) hs_c = c;
            @(posedge clk);
            s = mstep(s, 15, 9, 2, 4);
            @(negedge clk);
        end
        checks++;
        if (h10_c !== 20 || hs_c !== 23) begin
            errors++;
            $display("FAIL divpipe_hsdelay got h10=%0d hs=%0d want 20 23", h10_c, hs_c);
        end
        checks++;
        if (wrap_c !== 4320 || nfs !== 17) begin
            errors++;
            $display("FAIL divpipe_wrap got wrap=%0d fs=%0d want 4320 17", wrap_c, nfs);
        end
    endtask

    task automatic test_pipe0;
        mst_t s;
        logic [4:0] q[$];
        logic [4:0] e;
        logic ce, ls, fs;
        logic [30:0] obs, exp;
        logic [2:0] prev_fc;
        int wrap_c;
        s = '{0, 0, 0, 0};
        q = {};
        wrap_c = -1;
        prev_fc = 3'd0;
        do_reset;
        for (int c = 0; c < 635; c++) begin
            ce = 1'b1;
            ls = s.h == 0;
            fs = ls && s.v == 0;
            q.push_back(mraw(s.h, s.v, 6, 1, 2, 4, 1, 1));
            e = q.pop_front();
            exp = {ce, 10'(s.h), 10'(s.v), 3'(s.f), e, ls, fs};
            obs = {c2_pix, c2_h, c2_v, c2_fc, c2_hs, c2_vs, c2_de, c2_hb, c2_vb, c2_ls, c2_fs};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pipe0_cyc%0d got %h want %h", c, obs, exp);
            end
            if (c2_fc == 3'd0 && prev_fc == 3'd7) wrap_c = c;
            prev_fc = c2_fc;
            @(posedge clk);
            s = mstep(s, 10, 7, 1, 3);
            @(negedge clk);
        end
        checks++;
        if (wrap_c !== 560) begin
            errors++;
            $display("FAIL pipe0_wrap got %0d want 560", wrap_c);
        end
    endtask

`ifdef VGA_TIMING_GENLOCK_EN
    task automatic test_restart;
        int n;
        do_reset;
        n = 0;
        while (!(c2_h == 10'd3 && c2_v == 10'd2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 23) begin
            errors++;
            $display("FAIL restart_reach got %0d cycles want 23", n);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if ({c2_h, c2_v, c2_fs, c2_fc} !== {10'd0, 10'd0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL restart_mid got h=%0d v=%0d fs=%b fc=%0d want 0 0 1 0",
                     c2_h, c2_v, c2_fs, c2_fc);
        end
        n = 0;
        while (!(c2_h == 10'd9 && c2_v == 10'd6) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 69) begin
            errors++;
            $display("FAIL restart_reach2 got %0d cycles want 69", n);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if ({c2_h, c2_v, c2_fc} !== {10'd0, 10'd0, 3'd0}) begin
            errors++;
            $display("FAIL restart_wrap got h=%0d v=%0d fc=%0d want 0 0 0", c2_h, c2_v, c2_fc);
        end
    endtask
`endif

    task automatic test_async_reset;
        do_reset;
        repeat (300) @(negedge clk);
        checks++;
        if ({c0_h, c0_de, c2_fc} !== {10'd300, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL arst_pre got h=%0d de=%b fc2=%0d want 300 1 4", c0_h, c0_de, c2_fc);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({c0_h, c0_v, c0_hs, c0_vs, c0_de, c0_hb, c0_vb} !== {10'd0, 10'd0, 5'b00000}) begin
            errors++;
            $display("FAIL arst_u0 got h=%0d v=%0d hs=%b vs=%b de=%b hb=%b vb=%b want 0s",
                     c0_h, c0_v, c0_hs, c0_vs, c0_de, c0_hb, c0_vb);
        end
        checks++;
        if ({c1_h, c1_v, c1_hs, c1_vs, c1_de, c2_fc} !== {10'd0, 10'd0, 3'b110, 3'd0}) begin
            errors++;
            $display("FAIL arst_u1u2 got h=%0d v=%0d hs=%b vs=%b de=%b fc2=%0d want 0 0 1 1 0 0",
                     c1_h, c1_v, c1_hs, c1_vs, c1_de, c2_fc);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_defaults;
        test_div_pipe;
        test_pipe0;
`ifdef VGA_TIMING_GENLOCK_EN
        test_restart;
`endif
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
